// File: rtl/seq_detect_prog_if.sv
// Bus bundle for the programmable serial pattern detector: serial input,
// configuration inputs and the match/status outputs.
interface seq_detect_prog_if #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = 4,
  parameter int CNT_W   = 16
);
  logic               IN;
  logic               IN_VALID;
  logic               CFG_LOAD;
  logic [MAX_LEN-1:0] PAT;
  logic [LEN_W-1:0]   PAT_LEN;
  logic               OVERLAP;
  logic               CNT_CLR;
  logic               MATCH;
  logic [CNT_W-1:0]   MATCH_CNT;
  logic               ARMED;
  logic               CFG_ERR;

  modport master (
    output IN, IN_VALID, CFG_LOAD, PAT, PAT_LEN, OVERLAP, CNT_CLR,
    input  MATCH, MATCH_CNT, ARMED, CFG_ERR
  );

  modport slave (
    input  IN, IN_VALID, CFG_LOAD, PAT, PAT_LEN, OVERLAP, CNT_CLR,
    output MATCH, MATCH_CNT, ARMED, CFG_ERR
  );
endinterface

// File: rtl/seq_detect_prog.sv
// Programmable serial bit-pattern detector with overlapping/non-overlapping
// modes, a registered MATCH pulse and a saturating match counter.
module seq_detect_prog #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = 4,
  parameter int CNT_W   = 16
) (
  input logic              CLK,
  input logic              RST,
  seq_detect_prog_if.slave bus
);

  typedef enum logic {UNCFG = 1'b0, HUNT = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [MAX_LEN-1:0] pat_q, hist_q, hist_new, mask;
  logic [LEN_W-1:0]   len_q, fill_q, fill_new;
  logic [CNT_W-1:0]   cnt_q;
  logic               ovl_q, err_q, match_q;
  logic               len_ok, bit_take, match_now;

  always_ff @(posedge CLK) begin
    if (RST) state_q <= UNCFG;
    else     state_q <= state_d;
  end

  always_comb begin
    len_ok  = (bus.PAT_LEN != '0) && (int'(bus.PAT_LEN) <= MAX_LEN);
    state_d = state_q;
    if (bus.CFG_LOAD) state_d = len_ok ? HUNT : UNCFG;
  end

  // A bit arriving together with CFG_LOAD is dropped; only the low len bits take part in the compare.
  always_comb begin
    bit_take = (state_q == HUNT) && bus.IN_VALID && !bus.CFG_LOAD;
    hist_new = {hist_q[MAX_LEN-2:0], bus.IN};
    fill_new = (int'(fill_q) >= MAX_LEN) ? fill_q : fill_q + 1'b1;
    mask     = '0;
    for (int i = 0; i < MAX_LEN; i++) mask[i] = (i < int'(len_q));
    match_now = bit_take && (int'(fill_new) >= int'(len_q)) &&
                (((hist_new ^ pat_q) & mask) == '0);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      pat_q   <= '0;
      len_q   <= '0;
      ovl_q   <= 1'b0;
      err_q   <= 1'b0;
      hist_q  <= '0;
      fill_q  <= '0;
      match_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      match_q <= match_now;
      if (bus.CFG_LOAD) begin
        err_q  <= !len_ok;
        hist_q <= '0;
        fill_q <= '0;
        if (len_ok) begin
          pat_q <= bus.PAT;
          len_q <= bus.PAT_LEN;
          ovl_q <= bus.OVERLAP;
        end
      end else if (bit_take) begin
        hist_q <= hist_new;
        fill_q <= (match_now && !ovl_q) ? '0 : fill_new;
      end
      if (bus.CNT_CLR)                  cnt_q <= '0;
      else if (match_now && cnt_q != '1) cnt_q <= cnt_q + 1'b1;
    end
  end

  assign bus.MATCH     = match_q;
  assign bus.MATCH_CNT = cnt_q;
  assign bus.ARMED     = (state_q == HUNT);
  assign bus.CFG_ERR   = err_q;

endmodule

// File: tb/tb_seq_detect_prog.sv
// Scoreboard bench for seq_detect_prog: a wide-counter and a 2-bit-counter
// instance see identical stimulus and are checked against a bit-queue model.
module tb_seq_detect_prog;

  localparam int MAXL = 8;

  typedef struct {
    logic match;
    int   cnt_a;
    int   cnt_b;
    logic armed;
    logic err;
  } exp_t;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  always #5 CLK = ~CLK;

  seq_detect_prog_if #(.MAX_LEN(MAXL), .LEN_W(4), .CNT_W(16)) bus_a ();
  seq_detect_prog_if #(.MAX_LEN(MAXL), .LEN_W(4), .CNT_W(2))  bus_b ();

  seq_detect_prog #(.MAX_LEN(MAXL), .LEN_W(4), .CNT_W(16)) dut_a (
    .CLK(CLK), .RST(RST), .bus(bus_a.slave));
  seq_detect_prog #(.MAX_LEN(MAXL), .LEN_W(4), .CNT_W(2)) dut_b (
    .CLK(CLK), .RST(RST), .bus(bus_b.slave));

  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];

  bit         model_q[$];
  logic [7:0] m_pat = '0;
  int         m_len = 0;
  logic       m_ovl = 1'b0;
  logic       m_armed = 1'b0;
  logic       m_err = 1'b0;
  int         m_cnt_a = 0;
  int         m_cnt_b = 0;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  // Drives one cycle on both instances, predicts the post-edge outputs, then checks them.
  task automatic applyStimulus(input logic b, input logic valid, input logic cfg,
                               input logic [7:0] pat, input logic [3:0] len,
                               input logic ovl, input logic clr, input logic rst);
    exp_t e;
    logic hit;
    @(negedge CLK);
    RST = rst;
    bus_a.IN = b;   bus_a.IN_VALID = valid; bus_a.CFG_LOAD = cfg; bus_a.PAT = pat;
    bus_a.PAT_LEN = len; bus_a.OVERLAP = ovl; bus_a.CNT_CLR = clr;
    bus_b.IN = b;   bus_b.IN_VALID = valid; bus_b.CFG_LOAD = cfg; bus_b.PAT = pat;
    bus_b.PAT_LEN = len; bus_b.OVERLAP = ovl; bus_b.CNT_CLR = clr;

    hit = 1'b0;
    if (rst) begin
      model_q.delete();
      m_pat = '0; m_len = 0; m_ovl = 1'b0; m_armed = 1'b0; m_err = 1'b0;
      m_cnt_a = 0; m_cnt_b = 0;
    end else begin
      if (cfg) begin
        if (len >= 1 && len <= MAXL) begin
          m_pat = pat; m_len = int'(len); m_ovl = ovl;
          m_armed = 1'b1; m_err = 1'b0;
          model_q.delete();
        end else begin
          m_armed = 1'b0; m_err = 1'b1;
        end
      end else if (m_armed && valid) begin
        model_q.push_back(b);
        if (model_q.size() > MAXL) model_q.delete(0);
        if (model_q.size() >= m_len) begin
          hit = 1'b1;
          for (int k = 0; k < m_len; k++)
            if (model_q[model_q.size() - 1 - k] != m_pat[k]) hit = 1'b0;
        end
        if (hit && !m_ovl) model_q.delete();
      end
      if (clr) begin
        m_cnt_a = 0; m_cnt_b = 0;
      end else if (hit) begin
        if (m_cnt_a < 65535) m_cnt_a++;
        if (m_cnt_b < 3)     m_cnt_b++;
      end
    end
    e.match = hit; e.cnt_a = m_cnt_a; e.cnt_b = m_cnt_b; e.armed = m_armed; e.err = m_err;
    sb_q.push_back(e);

    @(posedge CLK);
    #1;
    e = sb_q.pop_front();
    checkOutput("match_a", 32'(bus_a.MATCH), 32'(e.match));
    checkOutput("match_b", 32'(bus_b.MATCH), 32'(e.match));
    checkOutput("cnt_a", 32'(bus_a.MATCH_CNT), e.cnt_a);
    checkOutput("cnt_b", 32'(bus_b.MATCH_CNT), e.cnt_b);
    checkOutput("armed", 32'(bus_a.ARMED), 32'(e.armed));
    checkOutput("cfg_err", 32'(bus_a.CFG_ERR), 32'(e.err));
    checkOutput("armed_b", 32'(bus_b.ARMED), 32'(e.armed));
  endtask

  task automatic sendBit(input logic b);
    applyStimulus(b, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic loadCfg(input logic [7:0] pat, input logic [3:0] len, input logic ovl);
    applyStimulus(1'b0, 1'b0, 1'b1, pat, len, ovl, 1'b0, 1'b0);
  endtask

  task automatic clearCnt();
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic sendWord(input logic [15:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) sendBit(bits[i]);
  endtask

  initial begin
    bus_a.IN = 0; bus_a.IN_VALID = 0; bus_a.CFG_LOAD = 0; bus_a.PAT = '0;
    bus_a.PAT_LEN = '0; bus_a.OVERLAP = 0; bus_a.CNT_CLR = 0;
    bus_b.IN = 0; bus_b.IN_VALID = 0; bus_b.CFG_LOAD = 0; bus_b.PAT = '0;
    bus_b.PAT_LEN = '0; bus_b.OVERLAP = 0; bus_b.CNT_CLR = 0;

    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b1);
    // Unconfigured: valid bits must be ignored.
    for (int i = 0; i < 4; i++) sendBit(1'b1);

    $display("[TB] pattern 10011 overlapping");
    loadCfg(8'b0001_0011, 4'd5, 1'b1);
    sendWord(16'b10_0111_0011, 10);

    $display("[TB] pattern 101 overlapping then non-overlapping");
    clearCnt();
    loadCfg(8'b0000_0101, 4'd3, 1'b1);
    sendWord(16'b10101, 5);
    loadCfg(8'b0000_0101, 4'd3, 1'b0);
    sendWord(16'b10101, 5);

    $display("[TB] illegal lengths");
    loadCfg(8'hFF, 4'd0, 1'b1);
    for (int i = 0; i < 3; i++) sendBit(1'b1);
    loadCfg(8'hFF, 4'd9, 1'b1);
    for (int i = 0; i < 10; i++) sendBit(1'b1);
    loadCfg(8'b1010_0110, 4'd4, 1'b0);
    sendWord(16'b0110_0110, 8);

    $display("[TB] len 1 saturation and clear on match");
    clearCnt();
    loadCfg(8'h01, 4'd1, 1'b1);
    for (int i = 0; i < 6; i++) sendBit(1'b1);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b0);
    sendBit(1'b1);
    sendBit(1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, 8'h01, 4'd1, 1'b1, 1'b0, 1'b0);

    $display("[TB] full length pattern");
    loadCfg(8'hA5, 4'd8, 1'b1);
    sendWord(16'b1010_0101_1010_0101, 16);

    $display("[TB] random stream");
    loadCfg(8'b0000_0110, 4'd3, 1'b0);
    for (int i = 0; i < 80; i++)
      applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0), 1'b0,
                    8'h00, 4'd0, 1'b0, 1'($urandom_range(0, 15) == 0), 1'b0);

    $display("[TB] pattern 0110 with gaps");
    loadCfg(8'b0000_0110, 4'd4, 1'b0);
    for (int i = 3; i >= 0; i--) begin
      idle($urandom_range(0, 3));
      sendBit(1'(4'b0110 >> i));
    end
    idle(2);
    loadCfg(8'b0000_0110, 4'd4, 1'b0);
    sendBit(1'b0); idle(2); sendBit(1'b1); idle(1); sendBit(1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b1);
    sendBit(1'b0);
    loadCfg(8'b0000_0110, 4'd4, 1'b0);
    sendBit(1'b1); sendBit(1'b1); sendBit(1'b0);
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seq_detect_prog.md
# seq_detect_prog

Programmable serial bit-pattern detector, the parametrised successor to the fixed-pattern MATCH FSMs in the serial front end. It watches a one-bit serial stream qualified by a valid strobe and compares it against a runtime-loaded pattern of 1..MAX_LEN bits, in overlapping or non-overlapping mode. It emits a registered one-cycle MATCH pulse and keeps a saturating match counter for status readout.

## Interface
- MAX_LEN, 8: maximum pattern length in bits (2..32).
- LEN_W, 4: width of PAT_LEN; must hold MAX_LEN+1 values.
- CNT_W, 16: width of MATCH_CNT.
- CLK  in  1  single clock, all logic on rising edge.
- RST  in  1  reset, synchronous, active-high.
- IN  in  1  serial data bit.
- IN_VALID  in  1  IN is consumed on cycles where this is 1.
- CFG_LOAD  in  1  one-cycle strobe: latch PAT, PAT_LEN, OVERLAP.
- PAT  in  MAX_LEN  pattern; bit PAT_LEN-1 is the first bit received, bit 0 the last.
- PAT_LEN  in  LEN_W  pattern length.
- OVERLAP  in  1  1 = overlapping detection, 0 = non-overlapping.
- CNT_CLR  in  1  synchronous clear of MATCH_CNT.
- MATCH  out  1  registered one-cycle pulse per detected pattern.
- MATCH_CNT  out  CNT_W  saturating count of matches.
- ARMED  out  1  valid configuration loaded, detection active.
- CFG_ERR  out  1  last CFG_LOAD had an illegal PAT_LEN.

## Operation
- Two-state control FSM: UNCFG and HUNT.
  - Reset enters UNCFG. Latched pattern, length and mode are 0. History and fill count are cleared.
  - In UNCFG, IN_VALID is ignored and MATCH stays 0.
- On CFG_LOAD in any state:
  - PAT_LEN in 1..MAX_LEN: latch PAT, PAT_LEN and OVERLAP; clear history and fill; CFG_ERR=0; go to HUNT.
  - PAT_LEN is 0 or greater than MAX_LEN: latch nothing; CFG_ERR=1; go to UNCFG.
- HUNT operation:
  - Shift history on each IN_VALID cycle: hist <= {hist[MAX_LEN-2:0], IN}.
  - Fill count increments and saturates at MAX_LEN.
  - Match condition for that bit: fill including the new bit >= len, and the low len bits of the new history equal the low len bits of the latched pattern. Bits of PAT above len are don't-care.
- After a match:
  - OVERLAP=1: history and fill are kept, so suffix/prefix overlap detects.
  - OVERLAP=0: fill resets to 0. The next match needs len fresh bits.
- MATCH_CNT:
  - Increments by 1 on each match and saturates at all-ones.
  - MATCH still pulses while saturated.
- Precedence:
  - RST beats everything.
  - CFG_LOAD in the same cycle as IN_VALID: the configuration is applied and the bit is discarded.
  - CNT_CLR in the same cycle as a match: MATCH pulses and MATCH_CNT becomes 0 (clear wins).
- ARMED = (state == HUNT).

## Timing
- Reset values: MATCH=0, MATCH_CNT=0, ARMED=0, CFG_ERR=0.
- MATCH is high exactly one cycle, the cycle after the IN_VALID cycle carrying the last pattern bit. MATCH_CNT updates on the same edge.
- Back-to-back IN_VALID with OVERLAP=1 and len=1 can assert MATCH on consecutive cycles.
- Gaps in IN_VALID are transparent: history is unchanged and matching spans gaps.
- Timing of ARMED and CFG_ERR relative to CFG_LOAD:
  - Both update one cycle after CFG_LOAD.
  - The first bit considered is on an IN_VALID in the cycle after CFG_LOAD.
- RST mid-stream: on the next edge all state clears, including the configuration. Outputs take their reset values, and a MATCH that would have fired on that edge is suppressed.
- CNT_CLR with no match: MATCH_CNT becomes 0 one cycle later.

## Test plan
- Pattern 10011, len 5, OVERLAP=1, stream 1,0,0,1,1,1,0,0,1,1 with IN_VALID continuous -> MATCH pulses after bit 5 and after bit 10; MATCH_CNT=2.
- Pattern 101, len 3, stream 1,0,1,0,1:
  - OVERLAP=1 -> matches after bits 3 and 5, MATCH_CNT=2.
  - Reload with OVERLAP=0 and resend -> single match after bit 3, MATCH_CNT=3.
- Invalid configuration (MAX_LEN=8):
  - CFG_LOAD with PAT_LEN=0, then with PAT_LEN=9 -> CFG_ERR=1, ARMED=0, no MATCH for any stream.
  - A following valid load (len 4) -> CFG_ERR=0, ARMED=1.
- CNT_W=2, pattern 1, len 1, OVERLAP=1, six valid 1 bits -> six MATCH pulses; MATCH_CNT=3 and holding.
  - CNT_CLR coincident with a match -> MATCH_CNT=0 the next cycle.
- Pattern 0110, len 4, bits sent with IN_VALID gaps of 0-3 cycles -> one match, one cycle after the final bit.
  - Repeat with RST asserted after 3 bits -> ARMED=0, MATCH_CNT=0, no MATCH.
  - After reload, 3 new bits alone produce no MATCH.
